ram_access_ctrl: RTL and testbench
==================================

// Module: ram_access_ctrl
// PURPOSE
//   Initiator side of the data-RAM command interface. Accepts one CPU memory request at a time on a
//   valid/ready handshake and drives the RAM strobes (we/load/PUSH/POP). Tracks a shadow stack pointer
//   and depth in step with the RAM, and returns read data or completion on a one-cycle response strobe.
//   Sits between the CPU execute stage and the 256x16 data RAM.
// PARAMETERS
//   ADDR_W       8    RAM address width; stack pointer width.
//   DATA_W       16   Data word width.
//   STACK_LIMIT  256  Maximum stack depth accepted before PUSH is refused (STACK_GUARD_EN only); 1..2**ADDR_W.
// PORTS
//   clk        in   1         Clock; all logic on rising edge.
//   rst        in   1         Synchronous active-high reset.
//   req_valid  in   1         CPU request valid.
//   req_ready  out  1         High only in IDLE; a request is accepted on req_valid & req_ready.
//   req_op     in   3         0 LOAD, 1 STORE, 2 PUSH, 3 POP, 4 PEEK (read top of stack, no pop); 5-7 illegal.
//   req_addr   in   ADDR_W    Address for LOAD/STORE; ignored otherwise.
//   req_wdata  in   DATA_W    Write data for STORE/PUSH.
//   rsp_valid  out  1         One-cycle completion pulse.
//   rsp_data   out  DATA_W    Read data (LOAD/POP/PEEK); 0 for STORE/PUSH/errors.
//   rsp_err    out  1         Valid with rsp_valid: request refused, no RAM access made.
//   ram_we     out  1         To RAM we.
//   ram_load   out  1         To RAM load.
//   ram_push   out  1         To RAM PUSH.
//   ram_pop    out  1         To RAM POP.
//   ram_addr   out  ADDR_W    To RAM addr.
//   ram_din    out  DATA_W    To RAM data_in.
//   ram_dout   in   DATA_W    From RAM data_out (registered in RAM, 1-cycle latency).
//   depth      out  ADDR_W+1  Current stack depth, 0..2**ADDR_W.
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_data=0; all ram_* strobes 0, ram_addr=0,
//     ram_din=0; shadow sp=all-ones (255); depth=0. Reset mid-operation aborts without a response or strobe;
//     the RAM shares rst, so both sp copies restart together.
//   - FSM IDLE -> ISSUE -> [CAPT] -> RESP -> IDLE. Accept in cycle T latches op/addr/wdata.
//   - ISSUE (T+1): exactly one strobe high for one cycle, all ram_* registered. LOAD: ram_load, ram_addr=addr.
//     STORE: ram_we, ram_addr=addr, ram_din=wdata. PUSH: ram_push, ram_din=wdata; sp-=1, depth+=1.
//     POP: ram_pop; sp+=1, depth-=1. PEEK: ram_load, ram_addr=sp+1 (mod 2**ADDR_W).
//   - Reads (LOAD/POP/PEEK): CAPT at T+2 registers ram_dout into rsp_data; RESP at T+3. Read latency 3, 4 cycles/op.
//   - Writes (STORE/PUSH): RESP at T+2, rsp_data=0. Latency 2, 3 cycles/op.
//   - RESP: rsp_valid=1 for exactly one cycle; rsp_data/rsp_err held until next response (not cleared).
//   - Illegal op (5-7): no strobe; IDLE -> RESP at T+1 with rsp_err=1, rsp_data=0.
//   - sp arithmetic modulo 2**ADDR_W, identical to the RAM pointer; depth saturates at 0 and 2**ADDR_W.
//   - No check for LOAD/STORE addresses overlapping stack region.
// CONFIGURATION
//   STACK_GUARD_EN defined: PUSH with depth==STACK_LIMIT, or POP/PEEK with depth==0, is refused: no strobe,
//     sp/depth unchanged, IDLE -> RESP at T+1 with rsp_err=1, rsp_data=0.
//   STACK_GUARD_EN undefined: PUSH/POP/PEEK always issued; sp wraps with the RAM; depth saturates; rsp_err
//     only for illegal ops. STACK_LIMIT unused.
// TESTING
//   1. STORE addr=0x10 data=0xBEEF, then LOAD 0x10 -> ram_we pulse at T+1, rsp_valid at T+2; LOAD rsp_data=0xBEEF at T+3.
//   2. PUSH 0x1111, PUSH 0x2222, PEEK, POP, POP -> ram_din 0x1111 then 0x2222; PEEK=0x2222 depth=2;
//      POPs return 0x2222 then 0x1111; depth 0, sp back to 255.
//   3. req_valid held during busy -> req_ready=0 in ISSUE/CAPT/RESP; second request accepted first IDLE cycle only.
//   4. req_op=6 -> no ram_* strobe; rsp_valid & rsp_err at T+1; rsp_data=0.
//   5. STACK_GUARD_EN, STACK_LIMIT=4: 5 PUSHes -> fifth rsp_err=1, depth=4, no ram_push; POP on empty -> rsp_err=1.
//   6. Without STACK_GUARD_EN: 257 PUSHes -> sp wraps 0->255, depth=256; rst asserted during CAPT ->
//      no rsp_valid, next cycle IDLE, depth=0, req_ready=1.

Source files
------------

// File: rtl/ram_access_ctrl_if.sv
// CPU-side request/response channel of ram_access_ctrl.
// The master drives requests; the slave (the controller) returns a one-cycle response strobe.
interface ram_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Initiator side of the data-RAM command interface: one CPU request at a time, RAM strobes, shadow sp/depth.
// Optional feature macro STACK_GUARD_EN: refuse PUSH at STACK_LIMIT depth and POP/PEEK on an empty stack.
module ram_access_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int STACK_LIMIT = 256
) (
    input  logic              clk,
    input  logic              rst,
    ram_access_ctrl_if.slave  req_if,
    output logic              ram_we_o,
    output logic              ram_load_o,
    output logic              ram_push_o,
    output logic              ram_pop_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    output logic [ADDR_W:0]   depth_o
);

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_PUSH  = 3'd2,
        OP_POP   = 3'd3,
        OP_PEEK  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPT,
        S_RESP
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_MAX = {1'b1, {ADDR_W{1'b0}}};
`ifdef STACK_GUARD_EN
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(STACK_LIMIT);
`endif

    state_e            state_q;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [ADDR_W:0]   depth_q, depth_d;
    logic              ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              ram_we_q, ram_load_q, ram_push_q, ram_pop_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_din_q;

    logic accept;
    logic op_illegal;
    logic guard_block;
    logic refuse;

    always_comb begin
        accept      = req_if.req_valid & ready_q;
        op_illegal  = (req_if.req_op > OP_PEEK);
`ifdef STACK_GUARD_EN
        guard_block = ((req_if.req_op == OP_PUSH) && (depth_q == LIMIT))
                   || (((req_if.req_op == OP_POP) || (req_if.req_op == OP_PEEK)) && (depth_q == '0));
`else
        guard_block = 1'b0;
`endif
        refuse      = op_illegal | guard_block;
    end

    // Shadow pointer moves on the same edge the RAM consumes its PUSH/POP strobe.
    always_comb begin
        sp_d    = sp_q;
        depth_d = depth_q;
        if (state_q == S_ISSUE) begin
            case (op_q)
                OP_PUSH: begin
                    sp_d = sp_q - 1'b1;
                    if (depth_q != DEPTH_MAX) depth_d = depth_q + 1'b1;
                end
                OP_POP: begin
                    sp_d = sp_q + 1'b1;
                    if (depth_q != '0) depth_d = depth_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            sp_q        <= '1;
            depth_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_load_q  <= 1'b0;
            ram_push_q  <= 1'b0;
            ram_pop_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
        end else begin
            sp_q       <= sp_d;
            depth_q    <= depth_d;
            ram_we_q   <= 1'b0;
            ram_load_q <= 1'b0;
            ram_push_q <= 1'b0;
            ram_pop_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= req_if.req_op;
                        ready_q <= 1'b0;
                        if (refuse) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            state_q <= S_ISSUE;
                            case (req_if.req_op)
                                OP_LOAD: begin
                                    ram_load_q <= 1'b1;
                                    ram_addr_q <= req_if.req_addr;
                                end
                                OP_STORE: begin
                                    ram_we_q   <= 1'b1;
                                    ram_addr_q <= req_if.req_addr;
                                    ram_din_q  <= req_if.req_wdata;
                                end
                                OP_PUSH: begin
                                    ram_push_q <= 1'b1;
                                    ram_din_q  <= req_if.req_wdata;
                                end
                                OP_POP: begin
                                    ram_pop_q <= 1'b1;
                                end
                                OP_PEEK: begin
                                    ram_load_q <= 1'b1;
                                    ram_addr_q <= sp_q + 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_ISSUE: begin
                    if ((op_q == OP_STORE) || (op_q == OP_PUSH)) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= '0;
                    end else begin
                        state_q <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    // RAM output register is valid one cycle after the strobe.
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= ram_dout_i;
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_if.req_ready = ready_q;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_err   = rsp_err_q;
    assign req_if.rsp_data  = rsp_data_q;
    assign ram_we_o         = ram_we_q;
    assign ram_load_o       = ram_load_q;
    assign ram_push_o       = ram_push_q;
    assign ram_pop_o        = ram_pop_q;
    assign ram_addr_o       = ram_addr_q;
    assign ram_din_o        = ram_din_q;
    assign depth_o          = depth_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 256x16 data RAM (registered output, PUSH/POP pointer).
`timescale 1ns/1ps
module tb_ram_access_ctrl;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
`ifdef STACK_GUARD_EN
    localparam int LIMIT = 4;
`else
    localparam int LIMIT = 256;
`endif
    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_PUSH  = 3'd2;
    localparam logic [2:0] OP_POP   = 3'd3;
    localparam logic [2:0] OP_PEEK  = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    logic              ram_we, ram_load, ram_push, ram_pop;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic [ADDR_W:0]   depth;
    wire  [3:0]        strb = {ram_we, ram_load, ram_push, ram_pop};

    ram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STACK_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_if     (bus),
        .ram_we_o   (ram_we),
        .ram_load_o (ram_load),
        .ram_push_o (ram_push),
        .ram_pop_o  (ram_pop),
        .ram_addr_o (ram_addr),
        .ram_din_o  (ram_din),
        .ram_dout_i (ram_dout),
        .depth_o    (depth)
    );

    // Data RAM: PUSH writes mem[sp] then decrements; POP increments then reads.
    logic [DATA_W-1:0] mem [256];
    logic [ADDR_W-1:0] m_sp;
    always @(posedge clk) begin
        if (rst) begin
            m_sp     <= 8'hFF;
            ram_dout <= '0;
        end else begin
            if (ram_we)   mem[ram_addr] <= ram_din;
            if (ram_load) ram_dout <= mem[ram_addr];
            if (ram_push) begin
                mem[m_sp] <= ram_din;
                m_sp      <= m_sp - 8'd1;
            end
            if (ram_pop) begin
                ram_dout <= mem[m_sp + 8'd1];
                m_sp     <= m_sp + 8'd1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    // Presents one request for one cycle; returns at the negedge of the ISSUE cycle (T+1).
    task automatic send(input logic [2:0] op, input logic [7:0] addr, input logic [15:0] wd);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err} !== 3'b100) begin errors++; $display("FAIL reset_ctrl got %b exp 100", {bus.req_ready, bus.rsp_valid, bus.rsp_err}); end
        checks++; if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL reset_rsp_data got %h exp 0000", bus.rsp_data); end
        checks++; if (strb !== 4'b0000) begin errors++; $display("FAIL reset_strobes got %b exp 0000", strb); end
        checks++; if ({ram_addr, ram_din} !== 24'h0) begin errors++; $display("FAIL reset_addr_din got %h exp 000000", {ram_addr, ram_din}); end
        checks++; if (depth !== 9'd0) begin errors++; $display("FAIL reset_depth got %0d exp 0", depth); end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        send(OP_STORE, 8'h10, 16'hBEEF);
        checks++; if (strb !== 4'b1000) begin errors++; $display("FAIL store_strobe got %b exp 1000", strb); end
        checks++; if ({ram_addr, ram_din} !== 24'h10BEEF) begin errors++; $display("FAIL store_addr_din got %h exp 10beef", {ram_addr, ram_din}); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL store_early_rsp got %b exp 0", bus.rsp_valid); end
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_err, strb} !== 6'b100000) begin errors++; $display("FAIL store_rsp got %b exp 100000", {bus.rsp_valid, bus.rsp_err, strb}); end
        checks++; if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL store_rsp_data got %h exp 0000", bus.rsp_data); end
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin errors++; $display("FAIL store_idle got %b exp 01", {bus.rsp_valid, bus.req_ready}); end
        send(OP_LOAD, 8'h10, 16'h0000);
        checks++; if ({strb, ram_addr} !== 12'h410) begin errors++; $display("FAIL load_issue got %h exp 410", {strb, ram_addr}); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL load_early_rsp got %b exp 0", bus.rsp_valid); end
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b10, 16'hBEEF}) begin errors++; $display("FAIL load_rsp got %b/%b/%h exp 1/0/beef", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
    endtask

    task automatic test_stack();
        send(OP_PUSH, 8'h00, 16'h1111);
        checks++; if ({strb, ram_din} !== {4'b0010, 16'h1111}) begin errors++; $display("FAIL push1_issue got %b/%h exp 0010/1111", strb, ram_din); end
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_data, depth} !== {1'b1, 16'h0000, 9'd1}) begin errors++; $display("FAIL push1_rsp got %b/%h/%0d exp 1/0000/1", bus.rsp_valid, bus.rsp_data, depth); end
        send(OP_PUSH, 8'h00, 16'h2222);
        checks++; if ({strb, ram_din} !== {4'b0010, 16'h2222}) begin errors++; $display("FAIL push2_issue got %b/%h exp 0010/2222", strb, ram_din); end
        @(negedge clk);
        checks++; if (depth !== 9'd2) begin errors++; $display("FAIL push2_depth got %0d exp 2", depth); end
        send(OP_PEEK, 8'h00, 16'h0000);
        checks++; if ({strb, ram_addr} !== 12'h4FE) begin errors++; $display("FAIL peek_issue got %h exp 4fe", {strb, ram_addr}); end
        repeat (2) @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_data, depth} !== {1'b1, 16'h2222, 9'd2}) begin errors++; $display("FAIL peek_rsp got %b/%h/%0d exp 1/2222/2", bus.rsp_valid, bus.rsp_data, depth); end
        send(OP_POP, 8'h00, 16'h0000);
        checks++; if (strb !== 4'b0001) begin errors++; $display("FAIL pop1_strobe got %b exp 0001", strb); end
        repeat (2) @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_data, depth} !== {1'b1, 16'h2222, 9'd1}) begin errors++; $display("FAIL pop1_rsp got %b/%h/%0d exp 1/2222/1", bus.rsp_valid, bus.rsp_data, depth); end
        send(OP_POP, 8'h00, 16'h0000);
        repeat (2) @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_data, depth} !== {1'b1, 16'h1111, 9'd0}) begin errors++; $display("FAIL pop2_rsp got %b/%h/%0d exp 1/1111/0", bus.rsp_valid, bus.rsp_data, depth); end
`ifndef STACK_GUARD_EN
        // sp restored to 255, so a peek addresses 255+1 wrapped to 0.
        send(OP_PEEK, 8'h00, 16'h0000);
        checks++; if ({strb, ram_addr} !== 12'h400) begin errors++; $display("FAIL peek_empty_addr got %h exp 400", {strb, ram_addr}); end
        repeat (2) @(negedge clk);
        checks++; if (depth !== 9'd0) begin errors++; $display("FAIL peek_empty_depth got %0d exp 0", depth); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_s;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_LOAD;
        bus.req_addr  = 8'h10;
        bus.req_wdata = 16'h0000;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL busy_ready_T got %b exp 1", bus.req_ready); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            exp_s = (i == 1) ? 4'b0100 : 4'b0000;
            checks++; if ({bus.req_ready, strb} !== {1'b0, exp_s}) begin errors++; $display("FAIL busy_cycle%0d got %b exp %b", i, {bus.req_ready, strb}, {1'b0, exp_s}); end
        end
        checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL busy_rsp1 got %b/%h exp 1/beef", bus.rsp_valid, bus.rsp_data); end
        @(negedge clk);
        checks++; if ({bus.req_ready, bus.rsp_valid, strb} !== 6'b100000) begin errors++; $display("FAIL busy_idle got %b exp 100000", {bus.req_ready, bus.rsp_valid, strb}); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++; if ({bus.req_ready, strb} !== 5'b00100) begin errors++; $display("FAIL busy_second_issue got %b exp 00100", {bus.req_ready, strb}); end
        repeat (2) @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_data} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL busy_rsp2 got %b/%h exp 1/beef", bus.rsp_valid, bus.rsp_data); end
    endtask

    task automatic test_illegal();
        send(3'd6, 8'h10, 16'h5555);
        checks++; if (strb !== 4'b0000) begin errors++; $display("FAIL illegal_strobe got %b exp 0000", strb); end
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL illegal_rsp got %b/%b/%h exp 1/1/0000", bus.rsp_valid, bus.rsp_err, bus.rsp_data); end
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 3'b011) begin errors++; $display("FAIL illegal_after got %b exp 011", {bus.rsp_valid, bus.rsp_err, bus.req_ready}); end
        checks++; if (depth !== 9'd0) begin errors++; $display("FAIL illegal_depth got %0d exp 0", depth); end
    endtask

`ifdef STACK_GUARD_EN
    task automatic test_stack_guard();
        for (int i = 0; i < 4; i++) begin
            send(OP_PUSH, 8'h00, 16'hA000 + 16'(i));
            @(negedge clk);
        end
        send(OP_PUSH, 8'h00, 16'hA004);
        checks++; if ({strb, bus.rsp_valid, bus.rsp_err} !== 6'b000011) begin errors++; $display("FAIL guard_push_full got %b exp 000011", {strb, bus.rsp_valid, bus.rsp_err}); end
        checks++; if (depth !== 9'd4) begin errors++; $display("FAIL guard_depth_full got %0d exp 4", depth); end
        for (int i = 0; i < 4; i++) begin
            send(OP_POP, 8'h00, 16'h0000);
            repeat (2) @(negedge clk);
        end
        checks++; if ({bus.rsp_data, depth} !== {16'hA000, 9'd0}) begin errors++; $display("FAIL guard_last_pop got %h/%0d exp a000/0", bus.rsp_data, depth); end
        send(OP_POP, 8'h00, 16'h0000);
        checks++; if ({strb, bus.rsp_valid, bus.rsp_err} !== 6'b000011) begin errors++; $display("FAIL guard_pop_empty got %b exp 000011", {strb, bus.rsp_valid, bus.rsp_err}); end
    endtask
`else
    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            send(OP_PUSH, 8'h00, 16'h1000 + 16'(i));
            @(negedge clk);
        end
        checks++; if (depth !== 9'h100) begin errors++; $display("FAIL wrap_depth256 got %0d exp 256", depth); end
        send(OP_PEEK, 8'h00, 16'h0000);
        checks++; if ({strb, ram_addr} !== 12'h400) begin errors++; $display("FAIL wrap_peek_addr got %h exp 400", {strb, ram_addr}); end
        repeat (2) @(negedge clk);
        checks++; if (bus.rsp_data !== 16'h10FF) begin errors++; $display("FAIL wrap_peek_data got %h exp 10ff", bus.rsp_data); end
        send(OP_PUSH, 8'h00, 16'h1100);
        checks++; if ({strb, ram_din} !== {4'b0010, 16'h1100}) begin errors++; $display("FAIL wrap_push257 got %b/%h exp 0010/1100", strb, ram_din); end
        @(negedge clk);
        checks++; if (depth !== 9'h100) begin errors++; $display("FAIL wrap_depth_sat got %0d exp 256", depth); end
        send(OP_PEEK, 8'h00, 16'h0000);
        checks++; if ({strb, ram_addr} !== 12'h4FF) begin errors++; $display("FAIL wrap_peek2_addr got %h exp 4ff", {strb, ram_addr}); end
        repeat (2) @(negedge clk);
        checks++; if (bus.rsp_data !== 16'h1100) begin errors++; $display("FAIL wrap_peek2_data got %h exp 1100", bus.rsp_data); end
    endtask
`endif

    task automatic test_reset_abort();
        send(OP_LOAD, 8'h10, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin errors++; $display("FAIL abort_ctrl got %b exp 01", {bus.rsp_valid, bus.req_ready}); end
        checks++; if ({depth, bus.rsp_data} !== 25'h0) begin errors++; $display("FAIL abort_state got %0d/%h exp 0/0000", depth, bus.rsp_data); end
        @(negedge clk);
        checks++; if ({bus.rsp_valid, strb} !== 5'b00000) begin errors++; $display("FAIL abort_late got %b exp 00000", {bus.rsp_valid, strb}); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        test_reset();
        test_store_load();
        test_stack();
        test_back_to_back();
        test_illegal();
`ifdef STACK_GUARD_EN
        test_stack_guard();
`else
        test_wrap();
`endif
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
